// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Hazard and flow controller for a 5-stage in-order pipeline.
//            Resolves memory-wait stalls, taken-branch flushes and load-use
//            interlocks, and keeps a saturating count of front-end stall
//            cycles.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in   pipeline clock, rising-edge active
//   rst_n           in   asynchronous active-low reset
//   id_ra_addr      in   ID-stage source register A
//   id_rb_addr      in   ID-stage source register B
//   id_uses_ra      in   ID instruction reads register A
//   id_uses_rb      in   ID instruction reads register B
//   ex_rd_addr      in   EX-stage destination register
//   ex_is_load      in   EX instruction is a memory load
//   branch_taken    in   EX resolved a taken branch (one-cycle pulse)
//   mem_req         in   MEM-stage access request
//   mem_ack         in   MEM-stage access completion
//   stall_count_clr in   synchronous clear of stall_count
//   stall_if        out  hold the PC
//   stall_id        out  hold the IF/ID register
//   stall_ex        out  hold the ID/EX register
//   ex_valid        out  ID/EX valid input (0 inserts a bubble)
//   flush_if_id     out  clear IF/ID to a no-op
//   stall_count     out  saturating count of cycles with stall_if=1
// ============================================================================
module pipe_ctrl #(
  parameter int REG_ADDR_W   = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_ra_addr,
  input  logic [REG_ADDR_W-1:0] id_rb_addr,
  input  logic                  id_uses_ra,
  input  logic                  id_uses_rb,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_is_load,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  input  logic                  stall_count_clr,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  stall_ex,
  output logic                  ex_valid,
  output logic                  flush_if_id,
  output logic [15:0]           stall_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_LOAD    = 3'(FLUSH_CYCLES);
  localparam logic [2:0] FLUSH_LOAD_M1 = 3'(FLUSH_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] flush_cnt, flush_cnt_nxt;
  logic       branch_pending, branch_pending_nxt;

  logic mem_busy;
  logic load_use;

  assign mem_busy = mem_req & ~mem_ack;
  assign load_use = ex_is_load && (ex_rd_addr != '0) &&
                    ((id_uses_ra && (id_ra_addr == ex_rd_addr)) ||
                     (id_uses_rb && (id_rb_addr == ex_rd_addr)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_RUN;
      flush_cnt      <= 3'd0;
      branch_pending <= 1'b0;
    end else begin
      state          <= state_nxt;
      flush_cnt      <= flush_cnt_nxt;
      branch_pending <= branch_pending_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    flush_cnt_nxt      = flush_cnt;
    branch_pending_nxt = branch_pending;
    stall_if           = 1'b0;
    stall_id           = 1'b0;
    stall_ex           = 1'b0;
    ex_valid           = 1'b1;
    flush_if_id        = 1'b0;

    if (mem_busy) begin
      // Freeze the whole front end; a branch seen now is remembered.
      // An interrupted flush is also remembered so the wrong-path
      // instructions still get squashed once memory completes.
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      state_nxt = ST_MEM_WAIT;
      if ((branch_taken && state != ST_FLUSH) || state == ST_FLUSH)
        branch_pending_nxt = 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if (branch_taken) begin
            // The branch cycle itself is the first bubble.
            flush_if_id = 1'b1;
            ex_valid    = 1'b0;
            if (FLUSH_CYCLES > 1) begin
              flush_cnt_nxt = FLUSH_LOAD_M1;
              state_nxt     = ST_FLUSH;
            end
          end else if (load_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            ex_valid = 1'b0;
          end
        end
        ST_MEM_WAIT: begin
          // Completion cycle: pipeline advances normally, no interlock.
          if (branch_pending || branch_taken) begin
            flush_cnt_nxt      = FLUSH_LOAD;
            branch_pending_nxt = 1'b0;
            state_nxt          = ST_FLUSH;
          end else begin
            state_nxt = ST_RUN;
          end
        end
        ST_FLUSH: begin
          // EX holds a bubble here, so branch_taken cannot be genuine.
          flush_if_id   = 1'b1;
          ex_valid      = 1'b0;
          flush_cnt_nxt = (flush_cnt == 3'd0) ? 3'd0 : flush_cnt - 3'd1;
          if (flush_cnt <= 3'd1)
            state_nxt = ST_RUN;
        end
        default: begin
          state_nxt = ST_RUN;
        end
      endcase
    end

    // While in reset nothing may advance into the pipeline.
    if (!rst_n) begin
      stall_if    = 1'b0;
      stall_id    = 1'b0;
      stall_ex    = 1'b0;
      ex_valid    = 1'b0;
      flush_if_id = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= 16'd0;
    end else if (stall_count_clr) begin
      stall_count <= 16'd0;
    end else if (stall_if && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Directed self-checking bench for pipe_ctrl (FLUSH_CYCLES=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  id_ra_addr = '0;
  logic [3:0]  id_rb_addr = '0;
  logic        id_uses_ra = 1'b0;
  logic        id_uses_rb = 1'b0;
  logic [3:0]  ex_rd_addr = '0;
  logic        ex_is_load = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_ack = 1'b0;
  logic        stall_count_clr = 1'b0;
  logic        stall_if, stall_id, stall_ex, ex_valid, flush_if_id;
  logic [15:0] stall_count;

  int vectors = 0;
  int miscompares = 0;

  pipe_ctrl #(.REG_ADDR_W(4), .FLUSH_CYCLES(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_ra_addr      (id_ra_addr),
    .id_rb_addr      (id_rb_addr),
    .id_uses_ra      (id_uses_ra),
    .id_uses_rb      (id_uses_rb),
    .ex_rd_addr      (ex_rd_addr),
    .ex_is_load      (ex_is_load),
    .branch_taken    (branch_taken),
    .mem_req         (mem_req),
    .mem_ack         (mem_ack),
    .stall_count_clr (stall_count_clr),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .stall_ex        (stall_ex),
    .ex_valid        (ex_valid),
    .flush_if_id     (flush_if_id),
    .stall_count     (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare the five control outputs as one packed word:
  // {stall_if, stall_id, stall_ex, ex_valid, flush_if_id}
  task automatic check_ctl(input string tag, input logic [4:0] exp);
    check(tag, {27'd0, stall_if, stall_id, stall_ex, ex_valid, flush_if_id}, {27'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use(input logic on);
    ex_is_load = on;
    ex_rd_addr = on ? 4'd3 : 4'd0;
    id_ra_addr = on ? 4'd3 : 4'd0;
    id_uses_ra = on;
  endtask

  localparam logic [4:0] CTL_IDLE  = 5'b00010;
  localparam logic [4:0] CTL_RESET = 5'b00001;
  localparam logic [4:0] CTL_LU    = 5'b11000;
  localparam logic [4:0] CTL_MEM   = 5'b11110;
  localparam logic [4:0] CTL_FLUSH = 5'b00001;

  initial begin
    // ---------------- reset state ----------------
    #2;
    check_ctl("reset_outputs", CTL_RESET);
    check("reset_count", {16'd0, stall_count}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check_ctl("idle_after_reset", CTL_IDLE);

    // ---------------- load-use ----------------
    set_load_use(1'b1);
    #1;
    check_ctl("lu_stall", CTL_LU);
    step();
    set_load_use(1'b0);
    #1;
    check_ctl("lu_released", CTL_IDLE);
    check("lu_count", {16'd0, stall_count}, 32'd1);
    ex_is_load = 1'b1; ex_rd_addr = 4'd0; id_ra_addr = 4'd0; id_uses_ra = 1'b1;
    #1;
    check_ctl("lu_rd0_nostall", CTL_IDLE);
    ex_rd_addr = 4'd5; id_ra_addr = 4'd1; id_rb_addr = 4'd5; id_uses_rb = 1'b1;
    #1;
    check_ctl("lu_rb_stall", CTL_LU);
    id_uses_rb = 1'b0;
    #1;
    check_ctl("lu_rb_unused", CTL_IDLE);
    ex_is_load = 1'b0; id_uses_ra = 1'b0; id_rb_addr = 4'd0; ex_rd_addr = 4'd0;
    step();

    // ---------------- branch flush ----------------
    branch_taken = 1'b1;
    set_load_use(1'b1);  // branch outranks load-use
    #1;
    check_ctl("br_cycle1", CTL_FLUSH);
    step();
    branch_taken = 1'b0;
    set_load_use(1'b0);
    #1;
    check_ctl("br_cycle2", CTL_FLUSH);
    step();
    check_ctl("br_done", CTL_IDLE);

    // ---------------- memory wait, 5 cycles ----------------
    stall_count_clr = 1'b1;
    step();
    stall_count_clr = 1'b0;
    check("mw_cleared", {16'd0, stall_count}, 32'd0);
    mem_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_ctl($sformatf("mw_stall_%0d", i), CTL_MEM);
      step();
    end
    check("mw_count", {16'd0, stall_count}, 32'd5);
    mem_ack = 1'b1;
    #1;
    check_ctl("mw_ack", CTL_IDLE);
    step();
    mem_req = 1'b0; mem_ack = 1'b0;
    #1;
    check_ctl("mw_back_run", CTL_IDLE);
    check("mw_count_hold", {16'd0, stall_count}, 32'd5);

    // ---------------- branch during a 4-cycle wait ----------------
    set_load_use(1'b1);
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      branch_taken = (i == 1);
      #1;
      check_ctl($sformatf("bw_stall_%0d", i), CTL_MEM);
      step();
    end
    branch_taken = 1'b0;
    mem_ack = 1'b1;
    #1;
    check_ctl("bw_ack_no_lu", CTL_IDLE);
    step();
    mem_req = 1'b0; mem_ack = 1'b0;
    #1;
    check_ctl("bw_flush1", CTL_FLUSH);
    step();
    check_ctl("bw_flush2", CTL_FLUSH);
    step();
    check_ctl("bw_run_lu", CTL_LU);
    set_load_use(1'b0);
    #1;
    check_ctl("bw_run_idle", CTL_IDLE);

    // ---------------- saturation and clear ----------------
    stall_count_clr = 1'b1;
    step();
    stall_count_clr = 1'b0;
    mem_req = 1'b1;
    for (int i = 0; i < 65534; i++) step();
    check("sat_fffe", {16'd0, stall_count}, 32'h0000FFFE);
    step();
    check("sat_ffff", {16'd0, stall_count}, 32'h0000FFFF);
    step(); step(); step();
    check("sat_hold", {16'd0, stall_count}, 32'h0000FFFF);
    stall_count_clr = 1'b1;
    #1;
    check_ctl("sat_clr_stalling", CTL_MEM);
    step();
    stall_count_clr = 1'b0;
    check("sat_clr_wins", {16'd0, stall_count}, 32'd0);
    mem_req = 1'b0;
    step();

    // ---------------- reset mid-FLUSH ----------------
    set_load_use(1'b1);
    step();
    set_load_use(1'b0);
    check("rf_count_pre", {16'd0, stall_count}, 32'd1);
    branch_taken = 1'b1;
    step();
    branch_taken = 1'b0;
    #1;
    check_ctl("rf_in_flush", CTL_FLUSH);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_ctl("rf_reset_outputs", CTL_RESET);
    check("rf_reset_count", {16'd0, stall_count}, 32'd0);
    #1;
    rst_n = 1'b1;
    #1;
    check_ctl("rf_release_run", CTL_IDLE);
    step();
    check_ctl("rf_first_cycle", CTL_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog: the sequence above is bounded, but guard against a stuck run.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
